// File: rtl/demux_stream_1to4.sv
// Registered valid/ready 1-to-4 demux: steers each accepted word into one of four
// per-channel holding registers. Define DEMUX_RR_EN to pick channels round-robin instead of by sel.
module demux_stream_1to4 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SNUM  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i,
  input  logic [SNUM-1:0]  sel,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [3:0]       o_valid,
  input  logic [3:0]       o_ready,
  output logic [SNUM-1:0]  cur_sel
);

  localparam int unsigned NCH = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  ch_state_t        state [NCH];
  logic [WIDTH-1:0] data  [NCH];
  logic             accept;

`ifdef DEMUX_RR_EN
  logic [SNUM-1:0] rr_ptr;
  logic            unused_sel;

  assign unused_sel = ^sel;
  assign cur_sel    = rr_ptr;

  // Pointer moves only when a word is actually taken, so a stall holds it
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= rr_ptr + SNUM'(1);
    end
  end
`else
  assign cur_sel = sel;
`endif

  // Stall only on the targeted channel; other channels never gate the input
  assign i_ready = ~o_valid[cur_sel] | o_ready[cur_sel];
  assign accept  = i_valid & i_ready;

  // Per-channel EMPTY/FULL machine; a refill wins over a drain in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NCH; n++) begin
        state[n] <= EMPTY;
        data[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (accept && (cur_sel == SNUM'(n))) begin
          state[n] <= FULL;
          data[n]  <= i;
        end else if ((state[n] == FULL) && o_ready[n]) begin
          state[n] <= EMPTY;
          data[n]  <= '0;
        end
      end
    end
  end

  always_comb begin
    o_valid = '0;
    for (int n = 0; n < NCH; n++) begin
      o_valid[n] = (state[n] == FULL);
    end
  end

  assign o0 = data[0];
  assign o1 = data[1];
  assign o2 = data[2];
  assign o3 = data[3];

endmodule

// File: tb/tb_demux_stream_1to4.sv
// Directed vector bench for demux_stream_1to4; handles both the sel-driven and
// the DEMUX_RR_EN round-robin builds.
module tb_demux_stream_1to4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i;
  logic [1:0] sel;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] o0, o1, o2, o3;
  logic [3:0] o_valid;
  logic [3:0] o_ready;
  logic [1:0] cur_sel;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  demux_stream_1to4 #(.WIDTH(8), .SNUM(2)) dut (
    .clk(clk), .rst(rst), .i(i), .sel(sel), .i_valid(i_valid), .i_ready(i_ready),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o_valid(o_valid), .o_ready(o_ready),
    .cur_sel(cur_sel)
  );

  typedef struct {
    logic       rst;
    logic [1:0] sel;
    logic [7:0] i;
    logic       iv;
    logic [3:0] ordy;
    logic       chk;   // pre-edge i_ready/cur_sel known (not before first reset)
    logic       ir;
    logic [1:0] cs;
    logic [3:0] ov;
    logic [7:0] e0, e1, e2, e3;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [1:0] s, logic [7:0] d, logic v, logic [3:0] rd,
                              logic c, logic ir, logic [1:0] cs, logic [3:0] ov,
                              logic [7:0] e0, logic [7:0] e1, logic [7:0] e2, logic [7:0] e3);
    vec_t t;
    t.rst = r; t.sel = s; t.i = d; t.iv = v; t.ordy = rd; t.chk = c; t.ir = ir; t.cs = cs;
    t.ov = ov; t.e0 = e0; t.e1 = e1; t.e2 = e2; t.e3 = e3;
    return t;
  endfunction

  task automatic check(string nm, int idx, logic [7:0] got, logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL vec%0d %s: got %h expected %h", idx, nm, got, exp);
    end
  endtask

  task automatic apply(vec_t v, int idx);
    rst = v.rst; sel = v.sel; i = v.i; i_valid = v.iv; o_ready = v.ordy;
    #1;
    if (v.chk) begin
      check("i_ready", idx, 8'(i_ready), 8'(v.ir));
      check("cur_sel", idx, 8'(cur_sel), 8'(v.cs));
    end
    @(posedge clk);
    #1;
    check("o_valid", idx, 8'(o_valid), 8'(v.ov));
    check("o0", idx, o0, v.e0);
    check("o1", idx, o1, v.e1);
    check("o2", idx, o2, v.e2);
    check("o3", idx, o3, v.e3);
  endtask

  initial begin
    rst = 1'b1; sel = '0; i = '0; i_valid = 1'b0; o_ready = '0;
`ifndef DEMUX_RR_EN
    // reset with i_valid high for two cycles
    vecs.push_back(mk(1, 0, 8'hFF, 1, 4'h0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'hFF, 1, 4'h0, 1, 1, 0, 4'b0000, 0, 0, 0, 0));
    // basic route and drain
    vecs.push_back(mk(0, 2, 8'hA5, 1, 4'hF, 1, 1, 2, 4'b0100, 0, 0, 8'hA5, 0));
    vecs.push_back(mk(0, 2, 8'h00, 0, 4'hF, 1, 1, 2, 4'b0000, 0, 0, 0, 0));
    // stall on channel 1, then drain+refill without a bubble
    vecs.push_back(mk(0, 1, 8'h11, 1, 4'h0, 1, 1, 1, 4'b0010, 0, 8'h11, 0, 0));
    vecs.push_back(mk(0, 1, 8'h22, 1, 4'h0, 1, 0, 1, 4'b0010, 0, 8'h11, 0, 0));
    vecs.push_back(mk(0, 1, 8'h22, 1, 4'h2, 1, 1, 1, 4'b0010, 0, 8'h22, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 0, 4'h2, 1, 1, 1, 4'b0000, 0, 0, 0, 0));
    // independent drain of channels 0 and 3 in one cycle
    vecs.push_back(mk(0, 0, 8'h01, 1, 4'h0, 1, 1, 0, 4'b0001, 8'h01, 0, 0, 0));
    vecs.push_back(mk(0, 3, 8'h03, 1, 4'h0, 1, 1, 3, 4'b1001, 8'h01, 0, 0, 8'h03));
    vecs.push_back(mk(0, 0, 8'h00, 0, 4'h9, 1, 1, 0, 4'b0000, 0, 0, 0, 0));
    // o_ready on empty channels is ignored
    vecs.push_back(mk(0, 2, 8'hEE, 0, 4'hF, 1, 1, 2, 4'b0000, 0, 0, 0, 0));
    // fill all four, then reset during an accept
    vecs.push_back(mk(0, 0, 8'hA0, 1, 4'h0, 1, 1, 0, 4'b0001, 8'hA0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'hA1, 1, 4'h0, 1, 1, 1, 4'b0011, 8'hA0, 8'hA1, 0, 0));
    vecs.push_back(mk(0, 2, 8'hA2, 1, 4'h0, 1, 1, 2, 4'b0111, 8'hA0, 8'hA1, 8'hA2, 0));
    vecs.push_back(mk(0, 3, 8'hA3, 1, 4'h0, 1, 1, 3, 4'b1111, 8'hA0, 8'hA1, 8'hA2, 8'hA3));
    vecs.push_back(mk(1, 0, 8'hBB, 1, 4'h1, 1, 1, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 4'h0, 1, 1, 0, 4'b0000, 0, 0, 0, 0));
    // stalled channel 2 blocks input despite other ready consumers
    vecs.push_back(mk(0, 2, 8'h55, 1, 4'h0, 1, 1, 2, 4'b0100, 0, 0, 8'h55, 0));
    vecs.push_back(mk(0, 2, 8'h66, 1, 4'hB, 1, 0, 2, 4'b0100, 0, 0, 8'h55, 0));
    vecs.push_back(mk(0, 0, 8'h77, 1, 4'h0, 1, 1, 0, 4'b0101, 8'h77, 0, 8'h55, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 4'hF, 1, 1, 0, 4'b0000, 0, 0, 0, 0));
`else
    // reset, then round-robin with sel held at 3 to show it is ignored
    vecs.push_back(mk(1, 3, 8'hFF, 1, 4'h0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3, 8'h00, 0, 4'h0, 1, 1, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3, 8'h10, 1, 4'hF, 1, 1, 0, 4'b0001, 8'h10, 0, 0, 0));
    vecs.push_back(mk(0, 3, 8'h11, 1, 4'hF, 1, 1, 1, 4'b0010, 0, 8'h11, 0, 0));
    vecs.push_back(mk(0, 3, 8'h12, 1, 4'hF, 1, 1, 2, 4'b0100, 0, 0, 8'h12, 0));
    vecs.push_back(mk(0, 3, 8'h13, 1, 4'hF, 1, 1, 3, 4'b1000, 0, 0, 0, 8'h13));
    vecs.push_back(mk(0, 3, 8'h14, 1, 4'hF, 1, 1, 0, 4'b0001, 8'h14, 0, 0, 0));
    // channel 1 consumer stalled; pointer must hold at 1 once it wraps back
    vecs.push_back(mk(0, 3, 8'h15, 1, 4'hD, 1, 1, 1, 4'b0010, 0, 8'h15, 0, 0));
    vecs.push_back(mk(0, 3, 8'h16, 1, 4'hD, 1, 1, 2, 4'b0110, 0, 8'h15, 8'h16, 0));
    vecs.push_back(mk(0, 3, 8'h17, 1, 4'hD, 1, 1, 3, 4'b1010, 0, 8'h15, 0, 8'h17));
    vecs.push_back(mk(0, 3, 8'h18, 1, 4'hD, 1, 1, 0, 4'b0011, 8'h18, 8'h15, 0, 0));
    vecs.push_back(mk(0, 3, 8'h19, 1, 4'hD, 1, 0, 1, 4'b0010, 0, 8'h15, 0, 0));
    vecs.push_back(mk(0, 3, 8'h19, 1, 4'h0, 1, 0, 1, 4'b0010, 0, 8'h15, 0, 0));
    vecs.push_back(mk(0, 3, 8'h19, 1, 4'h2, 1, 1, 1, 4'b0010, 0, 8'h19, 0, 0));
    vecs.push_back(mk(0, 3, 8'h00, 0, 4'hF, 1, 1, 2, 4'b0000, 0, 0, 0, 0));
`endif
    foreach (vecs[k]) apply(vecs[k], k);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
